// File: rtl/axi_lite_write_regfile.sv
// AXI4-Lite write-channel slave driving a bank of NUM_REGS control registers.
// AW and W are accepted in any order (or together). Once both are held, the
// decoded word index is committed for one cycle, then the B response waits
// for BREADY before the next transaction can be accepted.
// Optional feature macro: AXIL_WR_STRB_EN (per-byte write strobes honoured).
module axi_lite_write_regfile #(
  parameter int ADDRESS_SIZE = 32,
  parameter int DATA_SIZE    = 32,
  parameter int NUM_REGS     = 8,
  parameter logic [DATA_SIZE-1:0] RESET_VALUE = {DATA_SIZE{1'b0}}
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [ADDRESS_SIZE-1:0]       write_address,
  input  logic                          write_address_valid,
  output logic                          write_address_ready,
  input  logic [DATA_SIZE-1:0]          write_data,
  input  logic [DATA_SIZE/8-1:0]        write_data_strobe,
  input  logic                          write_data_valid,
  output logic                          write_data_ready,
  output logic [1:0]                    write_response,
  output logic                          write_response_valid,
  input  logic                          write_response_ready,
  output logic [NUM_REGS*DATA_SIZE-1:0] register_data,
  output logic [NUM_REGS-1:0]           register_write_enable
);

  localparam int ADDR_LSB = $clog2(DATA_SIZE / 8);
  localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int STRB_W   = DATA_SIZE / 8;
  localparam logic [IDX_W:0] NUM_REGS_W = (IDX_W + 1)'(NUM_REGS);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic                 r_awready;
  logic                 r_wready;
  logic                 r_bvalid;
  logic [1:0]           r_bresp;
  logic                 r_aw_got;
  logic                 r_w_got;
  logic [IDX_W-1:0]     r_idx;
  logic [DATA_SIZE-1:0] r_wdata;
  logic [DATA_SIZE-1:0] r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]  r_wen;

`ifdef AXIL_WR_STRB_EN
  logic [STRB_W-1:0]    r_wstrb;

  // Byte-merge new data into the old word under the strobe mask.
  function automatic logic [DATA_SIZE-1:0] f_merge_bytes(
    input logic [DATA_SIZE-1:0] old_word,
    input logic [DATA_SIZE-1:0] new_word,
    input logic [STRB_W-1:0]    strb
  );
    logic [DATA_SIZE-1:0] merged;
    merged = old_word;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) begin
        merged[8*b +: 8] = new_word[8*b +: 8];
      end else begin
        merged[8*b +: 8] = old_word[8*b +: 8];
      end
    end
    return merged;
  endfunction
`endif

  logic w_aw_hs;
  logic w_w_hs;
  logic w_b_hs;
  logic w_aw_done;
  logic w_w_done;
  logic w_idx_ok;
  logic w_awready_nxt;
  logic w_wready_nxt;
  logic w_bvalid_nxt;
  logic [1:0] w_bresp_nxt;
  logic w_commit;
  // Address bits outside the word index are aliased away on purpose.
  logic w_unused_bits;

  assign w_aw_hs   = write_address_valid & r_awready;
  assign w_w_hs    = write_data_valid & r_wready;
  assign w_b_hs    = (r_state == S_RESP) & r_bvalid & write_response_ready;
  assign w_aw_done = r_aw_got | w_aw_hs;
  assign w_w_done  = r_w_got | w_w_hs;
  assign w_idx_ok  = ({1'b0, r_idx} < NUM_REGS_W);
  assign w_unused_bits = ^{write_address, write_data_strobe};

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= S_RESET;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_RESET: w_next_state = S_FETCH;
      S_FETCH: begin
        if (w_aw_done && w_w_done) begin
          w_next_state = S_WRITE;
        end else begin
          w_next_state = S_FETCH;
        end
      end
      S_WRITE: w_next_state = S_RESP;
      S_RESP: begin
        if (w_b_hs) begin
          w_next_state = S_FETCH;
        end else begin
          w_next_state = S_RESP;
        end
      end
      default: w_next_state = S_RESET;
    endcase
  end

  // Output logic: next values of the handshake/response registers and commit strobe.
  always_comb begin
    w_awready_nxt = r_awready;
    w_wready_nxt  = r_wready;
    w_bvalid_nxt  = r_bvalid;
    w_bresp_nxt   = r_bresp;
    w_commit      = 1'b0;
    case (r_state)
      S_RESET: begin
        w_awready_nxt = 1'b1;
        w_wready_nxt  = 1'b1;
      end
      S_FETCH: begin
        if (w_aw_hs) begin
          w_awready_nxt = 1'b0;
        end else begin
          w_awready_nxt = r_awready;
        end
        if (w_w_hs) begin
          w_wready_nxt = 1'b0;
        end else begin
          w_wready_nxt = r_wready;
        end
      end
      S_WRITE: begin
        w_bvalid_nxt = 1'b1;
        w_commit     = w_idx_ok;
        if (w_idx_ok) begin
          w_bresp_nxt = RESP_OKAY;
        end else begin
          w_bresp_nxt = RESP_SLVERR;
        end
      end
      S_RESP: begin
        if (w_b_hs) begin
          w_bvalid_nxt  = 1'b0;
          w_awready_nxt = 1'b1;
          w_wready_nxt  = 1'b1;
        end else begin
          w_bvalid_nxt  = r_bvalid;
        end
      end
      default: begin
        w_awready_nxt = 1'b0;
        w_wready_nxt  = 1'b0;
        w_bvalid_nxt  = 1'b0;
      end
    endcase
  end

  // Registered handshake and response outputs.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
    end else begin
      r_awready <= w_awready_nxt;
      r_wready  <= w_wready_nxt;
      r_bvalid  <= w_bvalid_nxt;
      r_bresp   <= w_bresp_nxt;
    end
  end

  // Capture AW/W payloads and remember which channels are already held.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_aw_got <= 1'b0;
      r_w_got  <= 1'b0;
      r_idx    <= {IDX_W{1'b0}};
      r_wdata  <= {DATA_SIZE{1'b0}};
`ifdef AXIL_WR_STRB_EN
      r_wstrb  <= {STRB_W{1'b0}};
`endif
    end else if (r_state == S_FETCH) begin
      if (w_aw_hs) begin
        r_aw_got <= 1'b1;
        r_idx    <= write_address[ADDR_LSB +: IDX_W];
      end
      if (w_w_hs) begin
        r_w_got  <= 1'b1;
        r_wdata  <= write_data;
`ifdef AXIL_WR_STRB_EN
        r_wstrb  <= write_data_strobe;
`endif
      end
    end else if (w_b_hs) begin
      r_aw_got <= 1'b0;
      r_w_got  <= 1'b0;
    end
  end

  // Register bank update and one-cycle write-enable pulse on commit.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        r_regs[k] <= RESET_VALUE;
      end
      r_wen <= {NUM_REGS{1'b0}};
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        r_wen[k] <= w_commit && (r_idx == IDX_W'(k));
        if (w_commit && (r_idx == IDX_W'(k))) begin
`ifdef AXIL_WR_STRB_EN
          r_regs[k] <= f_merge_bytes(r_regs[k], r_wdata, r_wstrb);
`else
          r_regs[k] <= r_wdata;
`endif
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign register_data[g*DATA_SIZE +: DATA_SIZE] = r_regs[g];
  end

  assign write_address_ready   = r_awready;
  assign write_data_ready      = r_wready;
  assign write_response_valid  = r_bvalid;
  assign write_response        = r_bresp;
  assign register_write_enable = r_wen;

endmodule
